// File: rtl/fpu_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_mul_pkg
//  Description : Shared definitions for the sequential mantissa multiplier:
//                controller state encoding and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_mul_pkg;

    // Mantissa width including hidden bit (24 = single, 53 = double)
    localparam int DEFAULT_W  = 24;
    // Iteration counter width; 2**DEFAULT_CW must exceed DEFAULT_W
    localparam int DEFAULT_CW = 6;

    // 2'd3 is unused and is treated as IDLE by the controller
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : fpu_mul_pkg
`default_nettype wire

// File: rtl/mul_add_row.sv
`default_nettype none
// ============================================================================
//  Module      : mul_add_row
//  Description : One W-bit ripple-carry adder row (half adder at bit 0,
//                full-adder chain above). Purely combinational.
//  Ports       : A, B  in  W   addends
//                Sum   out W   A+B modulo 2**W
//                Cout  out 1   carry out of bit W-1
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_add_row
    import fpu_mul_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Sum,
    output logic         Cout
);

    // w_c[i] is the carry into bit i
    logic [W:1] w_c;

    assign Sum[0] = A[0] ^ B[0];
    assign w_c[1] = A[0] & B[0];

    for (genvar i = 1; i < W; i++) begin : g_fa
        assign Sum[i]   = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_c[W];

endmodule : mul_add_row
`default_nettype wire

// File: rtl/mant_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mant_mul_seq
//  Description : Sequential radix-2 shift-and-add mantissa multiplier. A single
//                W-bit adder row is reused over W cycles to form the 2W-bit
//                raw product A*B for the FPU multiply path.
//  Ports       : clk    in  1   rising-edge clock
//                rst    in  1   asynchronous active-high reset
//                start  in  1   request, accepted only while ready=1
//                abort  in  1   cancel an operation in RUN
//                A, B   in  W   multiplicand / multiplier, sampled on accept
//                ready  out 1   idle and able to accept
//                busy   out 1   iterating
//                done   out 1   one-cycle pulse, P valid
//                P      out 2W  product, held until the next completion
//  Revision    : 1.0 - initial release
// ============================================================================
module mant_mul_seq
    import fpu_mul_pkg::*;
#(
    parameter int W  = DEFAULT_W,
    parameter int CW = DEFAULT_CW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] P
);

    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    mcand_q;
    // Upper partial-product half. Its architectural bit W is always zero
    // after the right shift, so only W bits are stored.
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic [CW-1:0]   cnt_q;
    logic [2*W-1:0]  p_q;

    logic            w_idle;
    logic            w_accept;
    logic            w_iter;
    logic [W-1:0]    w_addend;
    logic [W-1:0]    w_sum;
    logic            w_cout;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    assign w_idle   = (state_q != RUN) && (state_q != DONE);
    assign w_accept = w_idle && start;
    assign w_iter   = (state_q == RUN) && !abort;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (abort)
                    state_d = IDLE;
                else if (cnt_q == C_LAST)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            // IDLE and the unused encoding behave identically
            default: state_d = start ? RUN : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    assign ready = w_idle;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign P     = p_q;

    // ------------------------------------------------------------------
    // Datapath: hi + (lo[0] ? mcand : 0), then shift {cout,sum,lo} right
    // ------------------------------------------------------------------
    assign w_addend = lo_q[0] ? mcand_q : '0;

    mul_add_row #(
        .W (W)
    ) u_row (
        .A    (hi_q),
        .B    (w_addend),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else if (w_accept) begin
            mcand_q <= A;
            hi_q    <= '0;
            lo_q    <= B;
            cnt_q   <= '0;
        end else if (w_iter) begin
            hi_q  <= {w_cout, w_sum[W-1:1]};
            lo_q  <= {w_sum[0], lo_q[W-1:1]};
            cnt_q <= cnt_q + CW'(1);
            // Capture the shifted result directly on the final iteration
            if (cnt_q == C_LAST)
                p_q <= {w_cout, w_sum, lo_q[W-1:1]};
        end
    end

endmodule : mant_mul_seq
`default_nettype wire

// File: tb/tb_mant_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mant_mul_seq
//  Description : Self-checking bench for mant_mul_seq (W=24): directed vector
//                table, multi-cycle corner sequences and randomized operands
//                against an arithmetic reference A*B, with a per-cycle
//                ready/busy/done protocol monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mant_mul_seq;

    localparam int W       = 24;
    localparam int CW      = 6;
    localparam int N_RAND  = 2000;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] P;

    int vectors   = 0;
    int errors    = 0;
    int done_cnt  = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    mant_mul_seq #(
        .W  (W),
        .CW (CW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: the product by plain arithmetic
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] x;
        logic [2*W-1:0] y;
        x = {{W{1'b0}}, a};
        y = {{W{1'b0}}, b};
        return x * y;
    endfunction

    // Protocol monitor: exactly one of ready/busy/done, done one cycle only,
    // and ready follows done.
    always @(negedge clk) begin
        if (rst) begin
            done_prev <= 1'b0;
        end else begin
            check("onehot_rbd", 64'($countones({ready, busy, done})), 64'd1);
            if (done_prev) begin
                check("done_width", 64'(done), 64'd0);
                check("ready_after_done", 64'(ready), 64'd1);
            end
            if (done) done_cnt++;
            done_prev <= done;
        end
    end

    // Called #1 after a rising edge. Waits for ready, issues one request,
    // then counts edges from the accept edge until done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit with_abort,
                          output logic [2*W-1:0] p, output int lat);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", 64'(ready), 64'd1);
        A = a; B = b; start = 1'b1; abort = with_abort;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        A = W'($urandom); B = W'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < W + 5);
        p = P;
    endtask

    vec_t           tbl[8];
    logic [2*W-1:0] p;
    logic [2*W-1:0] p_hold;
    logic [W-1:0]   ra, rb;
    int             lat;
    int             d0;

    initial begin
        tbl[0] = '{a: 24'h000001, b: 24'h000001, p: 48'h000000000001};
        tbl[1] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, p: 48'hFFFFFE000001};
        tbl[2] = '{a: 24'h800000, b: 24'h800000, p: 48'h400000000000};
        tbl[3] = '{a: 24'h000000, b: 24'h123456, p: 48'h000000000000};
        tbl[4] = '{a: 24'h000003, b: 24'h000005, p: 48'h00000000000F};
        tbl[5] = '{a: 24'hABCDEF, b: 24'h000002, p: 48'h000001579BDE};
        tbl[6] = '{a: 24'h123456, b: 24'h000000, p: 48'h000000000000};
        tbl[7] = '{a: 24'hFFFFFF, b: 24'h000001, p: 48'h000000FFFFFF};

        rst = 1'b1; start = 1'b0; abort = 1'b0; A = '0; B = '0;
        #23;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_P",     64'(P),     64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, 1'b0, p, lat);
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(W));
            check($sformatf("tbl%0d_P", i),   64'(p),   64'(tbl[i].p));
        end

        // Start held high through RUN and DONE: exactly one done
        @(posedge clk); #1;
        d0 = done_cnt;
        A = 24'h000000; B = 24'h123456; start = 1'b1;
        @(posedge clk); #1;                       // accept edge
        check("held_busy", 64'(busy), 64'd1);
        for (int i = 0; i < W + 1; i++) begin     // through edge W+1 (DONE -> IDLE)
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("held_ready", 64'(ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check("held_done_count", 64'(done_cnt - d0), 64'd1);
        check("held_P", 64'(P), 64'd0);
        check("held_idle", 64'(busy), 64'd0);

        // Abort in IDLE is ignored; abort together with start: start wins
        run_op(24'h000007, 24'h000009, 1'b1, p, lat);
        check("startabort_lat", 64'(lat), 64'(W));
        check("startabort_P",   64'(p),   64'd63);
        @(posedge clk); #1;

        // Abort on the 10th RUN cycle
        p_hold = P;
        d0 = done_cnt;
        A = 24'h00ABCD; B = 24'h00EF01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_busy",  64'(busy),  64'd0);
        check("abort_P",     64'(P),     64'(p_hold));
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_op(24'h000003, 24'h000005, 1'b0, p, lat);
        check("post_abort_P", 64'(p), 64'd15);

        // Asynchronous reset between edges in the middle of RUN
        @(posedge clk); #1;
        d0 = done_cnt;
        A = 24'h654321; B = 24'h0FEDCB; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("mrst_ready", 64'(ready), 64'd1);
        check("mrst_busy",  64'(busy),  64'd0);
        check("mrst_done",  64'(done),  64'd0);
        check("mrst_P",     64'(P),     64'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_no_done", 64'(done_cnt - d0), 64'd0);
        run_op(24'hABCDEF, 24'h000002, 1'b0, p, lat);
        check("post_rst_P", 64'(p), 64'h0000_0157_9BDE);

        // Randomized regression against the arithmetic reference
        for (int i = 0; i < N_RAND; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 15))
                0: ra = '0;
                1: rb = '0;
                2: ra = '1;
                3: rb = '1;
                default: ;
            endcase
            run_op(ra, rb, 1'b0, p, lat);
            check("rand_lat", 64'(lat), 64'(W));
            check("rand_P",   64'(p),   64'(ref_mul(ra, rb)));
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_mant_mul_seq
`default_nettype wire
